// File: rtl/sys_memory_mp.sv
// ---------------------------------------------------------------------------
// sys_memory_mp
// Multi-port synchronous data memory shared by the load/store units and the
// instruction fetch path. All ports address one word array.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   init_done          high once the post-reset clear sweep has finished
//   rd_valid/rd_ready  per read port request handshake (flattened vectors)
//   rd_addr            per read port word address, AW bits each
//   rd_rvalid          per read port response pulse, READ_LAT cycles after accept
//   rd_rdata           per read port response data, WIDTH bits each
//   rd_err             per read port response flag: address >= DEPTH
//   wr_valid/wr_ready  per write port request handshake
//   wr_addr/wr_data    per write port word address and data
//   wr_strb            per write port byte enables (WIDTH/8 bits each)
//   wr_bvalid          per write port response pulse, one cycle after accept
//   wr_err             per write port flag: address >= DEPTH, array untouched
// ---------------------------------------------------------------------------
module sys_memory_mp #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 1024,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int READ_LAT    = 1,
    parameter int WR_FIRST    = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            init_done,
    input  logic [READ_PORTS-1:0]           rd_valid,
    output logic [READ_PORTS-1:0]           rd_ready,
    input  logic [READ_PORTS*AW-1:0]        rd_addr,
    output logic [READ_PORTS-1:0]           rd_rvalid,
    output logic [READ_PORTS*WIDTH-1:0]     rd_rdata,
    output logic [READ_PORTS-1:0]           rd_err,
    input  logic [WRITE_PORTS-1:0]          wr_valid,
    output logic [WRITE_PORTS-1:0]          wr_ready,
    input  logic [WRITE_PORTS*AW-1:0]       wr_addr,
    input  logic [WRITE_PORTS*WIDTH-1:0]    wr_data,
    input  logic [WRITE_PORTS*WIDTH/8-1:0]  wr_strb,
    output logic [WRITE_PORTS-1:0]          wr_bvalid,
    output logic [WRITE_PORTS-1:0]          wr_err
);

    localparam int SB = WIDTH / 8;
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [AW-1:0]  clr_cnt_q;
    logic [AW-1:0]  clr_cnt_d;
    logic           running;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    ra      [READ_PORTS];
    logic [READ_PORTS-1:0] ra_ok;
    logic [READ_PORTS-1:0] rd_acc;
    logic [WIDTH-1:0] rd_word [READ_PORTS];

    logic [AW-1:0]    wa      [WRITE_PORTS];
    logic [WIDTH-1:0] wd      [WRITE_PORTS];
    logic [SB-1:0]    ws      [WRITE_PORTS];
    logic [WRITE_PORTS-1:0] wa_ok;
    logic [WRITE_PORTS-1:0] wr_acc;

    logic [READ_PORTS-1:0] pv_q [READ_LAT];
    logic [READ_PORTS-1:0] pe_q [READ_LAT];
    logic [WIDTH-1:0]      pd_q [READ_LAT][READ_PORTS];

    // There is no wrap-around: addresses from DEPTH up to 2^AW-1 are errors.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_V;
    endfunction

    // State register: reset always restarts the clear sweep from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: walk clr_cnt over every word once, then enter RUN.
    // The last word is cleared in the same cycle the FSM decides to leave.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Requests are only ever accepted in RUN; there is no backpressure there.
    always_comb begin
        running   = (state_q == ST_RUN);
        init_done = running;
        rd_ready  = {READ_PORTS{running}};
        wr_ready  = {WRITE_PORTS{running}};
    end

    // Unpack the flattened port vectors and form the accept/range qualifiers.
    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            ra[r]     = rd_addr[r*AW +: AW];
            ra_ok[r]  = addr_ok(ra[r]);
            rd_acc[r] = rd_valid[r] & running;
        end
        for (int p = 0; p < WRITE_PORTS; p++) begin
            wa[p]     = wr_addr[p*AW +: AW];
            wd[p]     = wr_data[p*WIDTH +: WIDTH];
            ws[p]     = wr_strb[p*SB +: SB];
            wa_ok[p]  = addr_ok(wa[p]);
            wr_acc[p] = wr_valid[p] & running;
        end
    end

    // Array update. During the sweep only the clear write happens. In RUN the
    // ports are visited from highest to lowest index so that, per byte, the
    // lowest-indexed port with its strobe set is the last assignment and wins.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            for (int p = WRITE_PORTS - 1; p >= 0; p--) begin
                if (wr_acc[p] && wa_ok[p]) begin
                    for (int b = 0; b < SB; b++) begin
                        if (ws[p][b]) begin
                            mem[wa[p]][8*b +: 8] <= wd[p][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Word presented to the read pipeline. With WR_FIRST set, bytes written in
    // this same cycle to the same address are forwarded over the stored word,
    // using the same lowest-port-wins priority as the array update.
    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_word[r] = ra_ok[r] ? mem[ra[r]] : '0;
            if (WR_FIRST != 0 && ra_ok[r]) begin
                for (int p = WRITE_PORTS - 1; p >= 0; p--) begin
                    if (wr_acc[p] && wa_ok[p] && (wa[p] == ra[r])) begin
                        for (int b = 0; b < SB; b++) begin
                            if (ws[p][b]) begin
                                rd_word[r][8*b +: 8] = wd[p][8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Read pipeline: stage 0 captures at the accept edge, so the last stage
    // presents the response exactly READ_LAT cycles later. Reset flushes every
    // stage so nothing in flight ever emerges afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < READ_LAT; s++) begin
                pv_q[s] <= '0;
                pe_q[s] <= '0;
                for (int r = 0; r < READ_PORTS; r++) begin
                    pd_q[s][r] <= '0;
                end
            end
        end else begin
            pv_q[0] <= rd_acc;
            for (int r = 0; r < READ_PORTS; r++) begin
                pe_q[0][r] <= rd_acc[r] & ~ra_ok[r];
                pd_q[0][r] <= rd_acc[r] ? rd_word[r] : '0;
            end
            for (int s = 1; s < READ_LAT; s++) begin
                pv_q[s] <= pv_q[s-1];
                pe_q[s] <= pe_q[s-1];
                for (int r = 0; r < READ_PORTS; r++) begin
                    pd_q[s][r] <= pd_q[s-1][r];
                end
            end
        end
    end

    // Read response outputs come straight from the final pipeline stage.
    always_comb begin
        rd_rvalid = pv_q[READ_LAT-1];
        rd_err    = pe_q[READ_LAT-1];
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_rdata[r*WIDTH +: WIDTH] = pd_q[READ_LAT-1][r];
        end
    end

    // Write responses: one pulse per accepted write, flagged when out of range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bvalid <= '0;
            wr_err    <= '0;
        end else begin
            wr_bvalid <= wr_acc;
            wr_err    <= wr_acc & ~wa_ok;
        end
    end

endmodule

// File: tb/tb_sys_memory_mp.sv
// ---------------------------------------------------------------------------
// tb_sys_memory_mp
// Self-checking bench for sys_memory_mp with DEPTH=1000 (non power of two),
// two read ports, two write ports, READ_LAT=3 and WR_FIRST=1.
// Stimulus pushes expected responses into per-port queues from a plain word
// array model; a negedge monitor pops and compares whenever a response pulses.
// ---------------------------------------------------------------------------
module tb_sys_memory_mp;

    localparam int W  = 32;
    localparam int D  = 1000;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int RL = 3;
    localparam int WF = 1;
    localparam int AW = $clog2(D);
    localparam int SB = W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_done;
    logic [RP-1:0]     rd_valid;
    logic [RP-1:0]     rd_ready;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP-1:0]     rd_rvalid;
    logic [RP*W-1:0]   rd_rdata;
    logic [RP-1:0]     rd_err;
    logic [WP-1:0]     wr_valid;
    logic [WP-1:0]     wr_ready;
    logic [WP*AW-1:0]  wr_addr;
    logic [WP*W-1:0]   wr_data;
    logic [WP*SB-1:0]  wr_strb;
    logic [WP-1:0]     wr_bvalid;
    logic [WP-1:0]     wr_err;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           due;
    } rexp_t;

    typedef struct {
        logic err;
        int   due;
    } wexp_t;

    rexp_t        rq [RP][$];
    wexp_t        wq [WP][$];
    logic [W-1:0] model_mem [D];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    sys_memory_mp #(
        .WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .WRITE_PORTS(WP),
        .READ_LAT(RL), .WR_FIRST(WF)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_err(rd_err),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_bvalid(wr_bvalid), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] pickAddr();
        case ($urandom_range(0, 7))
            0:       return AW'(D + $urandom_range(0, (1 << AW) - 1 - D));
            1:       return AW'(D - 1);
            2:       return AW'(7);
            3:       return AW'(9);
            default: return AW'($urandom_range(0, D - 1));
        endcase
    endfunction

    task automatic pushReads(input logic [RP-1:0] rv, input logic [RP*AW-1:0] ra);
        rexp_t e;
        int    a;
        for (int r = 0; r < RP; r++) begin
            if (rv[r]) begin
                a      = int'(ra[r*AW +: AW]);
                e.err  = (a >= D);
                e.data = (a < D) ? model_mem[a] : '0;
                e.due  = cyc + RL;
                rq[r].push_back(e);
            end
        end
    endtask

    // Drive one cycle of requests. If the memory is in RUN every valid request
    // is accepted at the coming edge, so the model is updated and expectations
    // queued here. Lower-indexed ports claim bytes first on shared addresses.
    task automatic applyStimulus(input logic [RP-1:0] rv, input logic [RP*AW-1:0] ra,
                                 input logic [WP-1:0] wv, input logic [WP*AW-1:0] wa,
                                 input logic [WP*W-1:0] wd, input logic [WP*SB-1:0] ws);
        wexp_t e;
        int    a;
        logic  claimed;
        rd_valid = rv;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        wr_strb  = ws;
        if (init_done) begin
            if (WF == 0) pushReads(rv, ra);
            for (int p = 0; p < WP; p++) begin
                if (wv[p]) begin
                    a     = int'(wa[p*AW +: AW]);
                    e.err = (a >= D);
                    e.due = cyc + 1;
                    wq[p].push_back(e);
                    if (a < D) begin
                        for (int b = 0; b < SB; b++) begin
                            claimed = 1'b0;
                            for (int q = 0; q < p; q++) begin
                                if (wv[q] && int'(wa[q*AW +: AW]) == a && ws[q*SB + b])
                                    claimed = 1'b1;
                            end
                            if (ws[p*SB + b] && !claimed)
                                model_mem[a][8*b +: 8] = wd[p*W + 8*b +: 8];
                        end
                    end
                end
            end
            if (WF != 0) pushReads(rv, ra);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, '0, '0, '0);
    endtask

    task automatic randomCycles(input int n, input int wr_pct);
        logic [RP-1:0]    rv;
        logic [RP*AW-1:0] ra;
        logic [WP-1:0]    wv;
        logic [WP*AW-1:0] wa;
        logic [WP*W-1:0]  wd;
        logic [WP*SB-1:0] ws;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < RP; r++) begin
                rv[r]          = ($urandom_range(0, 3) != 0);
                ra[r*AW +: AW] = pickAddr();
            end
            for (int p = 0; p < WP; p++) begin
                wv[p]          = ($urandom_range(0, 99) < wr_pct);
                wa[p*AW +: AW] = pickAddr();
                wd[p*W +: W]   = $urandom;
                ws[p*SB +: SB] = ($urandom_range(0, 7) == 0) ? '0 : SB'($urandom);
            end
            applyStimulus(rv, ra, wv, wa, wd, ws);
        end
    endtask

    // Assert reset for hold cycles, flush expectations and model, release,
    // and optionally time the clear sweep until init_done rises.
    task automatic doReset(input int hold, input bit wait_done);
        int start;
        int done_at;
        rst      = 1'b1;
        rd_valid = '0;
        wr_valid = '0;
        for (int p = 0; p < RP; p++) rq[p].delete();
        for (int p = 0; p < WP; p++) wq[p].delete();
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_init_done", init_done, 0);
            checkOutput("rst_rd_ready", rd_ready, 0);
            checkOutput("rst_wr_ready", wr_ready, 0);
        end
        rst   = 1'b0;
        start = cyc;
        if (wait_done) begin
            done_at = -1;
            for (int i = 0; i < D + 20; i++) begin
                @(posedge clk);
                #1;
                if (i == 0) checkOutput("clear_rd_ready", rd_ready, 0);
                if (init_done) begin
                    done_at = cyc;
                    break;
                end
            end
            checkOutput("sweep_length", 64'(done_at - start), 64'(D));
            checkOutput("run_rd_ready", rd_ready, {RP{1'b1}});
            checkOutput("run_wr_ready", wr_ready, {WP{1'b1}});
        end
    endtask

    // Monitor: during reset everything must be quiet; otherwise every response
    // pulse pops its port queue and is compared for data, flag and timing.
    always @(negedge clk) begin
        rexp_t re;
        wexp_t we;
        if (rst) begin
            checkOutput("rst_rd_rvalid", rd_rvalid, 0);
            checkOutput("rst_rd_rdata", rd_rdata, 0);
            checkOutput("rst_rd_err", rd_err, 0);
            checkOutput("rst_wr_bvalid", wr_bvalid, 0);
            checkOutput("rst_wr_err", wr_err, 0);
        end else begin
            for (int p = 0; p < RP; p++) begin
                if (rd_rvalid[p]) begin
                    if (rq[p].size() == 0) begin
                        checkOutput("rd_unexpected", rd_rvalid[p], 0);
                    end else begin
                        re = rq[p].pop_front();
                        checkOutput("rd_latency", 64'(cyc), 64'(re.due));
                        checkOutput("rd_rdata", rd_rdata[p*W +: W], re.data);
                        checkOutput("rd_err", rd_err[p], re.err);
                    end
                end else if (rq[p].size() > 0 && rq[p][0].due <= cyc) begin
                    re = rq[p].pop_front();
                    checkOutput("rd_missing", rd_rvalid[p], 1);
                end
            end
            for (int p = 0; p < WP; p++) begin
                if (wr_bvalid[p]) begin
                    if (wq[p].size() == 0) begin
                        checkOutput("wr_unexpected", wr_bvalid[p], 0);
                    end else begin
                        we = wq[p].pop_front();
                        checkOutput("wr_latency", 64'(cyc), 64'(we.due));
                        checkOutput("wr_err", wr_err[p], we.err);
                    end
                end else if (wq[p].size() > 0 && wq[p][0].due <= cyc) begin
                    we = wq[p].pop_front();
                    checkOutput("wr_missing", wr_bvalid[p], 1);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rd_valid = '0;
        rd_addr  = '0;
        wr_valid = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
        #1;
        doReset(3, 1'b1);

        // Freshly cleared memory: random reads only, all must return zero.
        randomCycles(20, 0);

        // Strobed write of word 5, then read it back.
        applyStimulus(2'b00, '0, 2'b01, {AW'(0), AW'(5)}, {32'h0, 32'hDEADBEEF}, {4'b0000, 4'b0101});
        applyStimulus(2'b01, {AW'(0), AW'(5)}, '0, '0, '0, '0);

        // Both write ports hit word 9 in one cycle, then read it on both ports.
        applyStimulus(2'b00, '0, 2'b11, {AW'(9), AW'(9)}, {32'h22222222, 32'h11111111}, {4'b1111, 4'b0011});
        applyStimulus(2'b11, {AW'(9), AW'(9)}, '0, '0, '0, '0);

        // Word 7 = 1, then same-cycle write 7 = 2 with reads of 7.
        applyStimulus(2'b00, '0, 2'b01, {AW'(0), AW'(7)}, {32'h0, 32'h1}, {4'b0000, 4'b1111});
        applyStimulus(2'b11, {AW'(7), AW'(7)}, 2'b01, {AW'(0), AW'(7)}, {32'h0, 32'h2}, {4'b0000, 4'b1111});

        // Range boundary: 1000 and 1023 are errors, 999 is the last valid word.
        applyStimulus(2'b11, {AW'(999), AW'(1000)}, 2'b11, {AW'(999), AW'(1000)},
                      {32'hCAFEF00D, 32'hFFFFFFFF}, {4'b1111, 4'b1111});
        applyStimulus(2'b11, {AW'(1023), AW'(999)}, 2'b01, {AW'(0), AW'(1023)}, {32'h0, 32'hFFFFFFFF}, {4'b0000, 4'b1111});
        applyStimulus(2'b00, '0, 2'b10, {AW'(999), AW'(0)}, {32'h12345678, 32'h0}, {4'b0000, 4'b0000});
        applyStimulus(2'b01, {AW'(0), AW'(999)}, '0, '0, '0, '0);
        idle(RL + 1);

        // Mixed random traffic with address collisions and out-of-range hits.
        randomCycles(400, 40);
        idle(RL + 1);

        // Back-to-back reads on both ports, reset while they are still in flight.
        applyStimulus(2'b11, {AW'(9), AW'(5)}, '0, '0, '0, '0);
        applyStimulus(2'b11, {AW'(7), AW'(999)}, '0, '0, '0, '0);
        doReset(2, 1'b1);
        randomCycles(60, 0);
        randomCycles(100, 40);

        // Reset in the middle of the sweep; requests during the sweep are refused.
        doReset(3, 1'b0);
        randomCycles(50, 50);
        doReset(2, 1'b1);
        randomCycles(100, 40);

        idle(RL + 2);
        for (int p = 0; p < RP; p++) checkOutput("rd_drain", 64'(rq[p].size()), 0);
        for (int p = 0; p < WP; p++) checkOutput("wr_drain", 64'(wq[p].size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
